// File: rtl/gcd.sv
// Binary (Stein) GCD of two 8-bit unsigned operands, one reduction step per clock.
// A load pulse in IDLE starts a run; done pulses once when res is updated.
module gcd (
   input  logic       clk,
   input  logic       resetb,
   input  logic [7:0] u,
   input  logic [7:0] v,
   input  logic       ld,
   output logic [7:0] res,
   output logic       done
);

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   state_t     state_q, state_d;
   logic [7:0] a_q, a_d;
   logic [7:0] b_q, b_d;
   logic [2:0] k_q, k_d;
   logic [7:0] res_q, res_d;
   logic       done_q, done_d;

   logic [7:0] diff_ab, diff_ba, a_shl, b_shl;

   assign diff_ab = a_q - b_q;
   assign diff_ba = b_q - a_q;
   // The common power of two never pushes the result past max(u,v), so truncation is safe.
   assign a_shl   = a_q << k_q;
   assign b_shl   = b_q << k_q;

   always_ff @(posedge clk or posedge resetb) begin
      if (resetb) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         k_q     <= '0;
         res_q   <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         k_q     <= k_d;
         res_q   <= res_d;
         done_q  <= done_d;
      end
   end

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      k_d     = k_q;
      res_d   = res_q;
      done_d  = 1'b0;
      case (state_q)
         IDLE: begin
            if (ld) begin
               a_d     = u;
               b_d     = v;
               k_d     = '0;
               state_d = CALC;
            end
         end
         CALC: begin
            if (a_q == 8'd0) begin
               res_d   = b_shl;
               done_d  = 1'b1;
               state_d = DONE;
            end else if (b_q == 8'd0) begin
               res_d   = a_shl;
               done_d  = 1'b1;
               state_d = DONE;
            end else if (!a_q[0] && !b_q[0]) begin
               a_d = a_q >> 1;
               b_d = b_q >> 1;
               k_d = k_q + 3'd1;
            end else if (!a_q[0]) begin
               a_d = a_q >> 1;
            end else if (!b_q[0]) begin
               b_d = b_q >> 1;
            end else if (a_q >= b_q) begin
               a_d = diff_ab >> 1;
            end else begin
               b_d = diff_ba >> 1;
            end
         end
         DONE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   assign res  = res_q;
   assign done = done_q;

endmodule

// File: tb/tb_gcd.sv
// Directed and random self-checking bench for gcd; expected values are
// hand-computed or come from a Euclidean remainder model.
module tb_gcd;

   logic       clk;
   logic       resetb;
   logic [7:0] u, v;
   logic       ld;
   logic [7:0] res;
   logic       done;

   int errs;
   int checks;

   gcd dut (
      .clk   (clk),
      .resetb(resetb),
      .u     (u),
      .v     (v),
      .ld    (ld),
      .res   (res),
      .done  (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input int obs, input int exp);
      checks++;
      if (obs !== exp) begin
         errs++;
         $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
      end
   endtask

   function automatic int ref_gcd(input int x, input int y);
      int p, q, t;
      p = x;
      q = y;
      while (q != 0) begin
         t = p % q;
         p = q;
         q = t;
      end
      return p;
   endfunction

   // One computation: load at a negedge, wait for done, check result,
   // single-cycle pulse and hold. noise: 1 = toggle ld during CALC,
   // 2 = scramble u/v during CALC.
   task automatic run(input string tag, input logic [7:0] uu, input logic [7:0] vv,
                      input int exp, input int noise);
      int lat;
      bit seen;
      @(negedge clk);
      u  = uu;
      v  = vv;
      ld = 1'b1;
      lat  = 0;
      seen = 1'b0;
      while (lat < 25 && !seen) begin
         @(negedge clk);
         lat++;
         if (done) begin
            seen = 1'b1;
            ld   = 1'b0;
         end else if (noise == 1) begin
            ld = 1'($urandom_range(0, 1));
         end else begin
            ld = 1'b0;
            if (noise == 2) begin
               u = 8'($urandom);
               v = 8'($urandom);
            end
         end
      end
      ld = 1'b0;
      chk({tag, " done_seen"}, int'(seen), 1);
      chk({tag, " latency_le_20"}, int'(lat <= 20), 1);
      chk({tag, " res"}, int'(res), exp);
      @(negedge clk);
      chk({tag, " done_one_cycle"}, int'(done), 0);
      @(negedge clk);
      chk({tag, " res_held"}, int'(res), exp);
      chk({tag, " no_second_done"}, int'(done), 0);
   endtask

   initial begin
      logic [7:0] ru, rv;
      bit         saw_done;
      errs   = 0;
      checks = 0;
      u      = 8'd0;
      v      = 8'd0;
      ld     = 1'b0;
      resetb = 1'b1;
      #1;
      chk("reset res", int'(res), 0);
      chk("reset done", int'(done), 0);
      repeat (2) @(negedge clk);
      resetb = 1'b0;

      run("48_18", 8'd48, 8'd18, 6, 0);
      run("0_5", 8'd0, 8'd5, 5, 0);
      run("7_0", 8'd7, 8'd0, 7, 0);
      run("0_0", 8'd0, 8'd0, 0, 0);
      run("128_96", 8'd128, 8'd96, 32, 0);
      run("255_255", 8'd255, 8'd255, 255, 0);
      run("1_200", 8'd1, 8'd200, 1, 0);
      run("128_128", 8'd128, 8'd128, 128, 0);
      run("84_36_scramble", 8'd84, 8'd36, 12, 2);

      // Abort mid-computation: no done pulse, registers cleared immediately.
      @(negedge clk);
      u  = 8'd200;
      v  = 8'd150;
      ld = 1'b1;
      @(negedge clk);
      ld = 1'b0;
      repeat (2) @(negedge clk);
      resetb = 1'b1;
      #1;
      chk("midreset res", int'(res), 0);
      chk("midreset done", int'(done), 0);
      saw_done = 1'b0;
      repeat (3) begin
         @(negedge clk);
         if (done) saw_done = 1'b1;
      end
      resetb = 1'b0;
      repeat (2) begin
         @(negedge clk);
         if (done) saw_done = 1'b1;
      end
      chk("midreset no_done", int'(saw_done), 0);
      chk("midreset res_after", int'(res), 0);
      run("200_150", 8'd200, 8'd150, 50, 0);

      for (int i = 0; i < 100; i++) begin
         ru = 8'($urandom);
         rv = 8'($urandom);
         run($sformatf("rnd%0d_%0d_%0d", i, ru, rv), ru, rv, ref_gcd(int'(ru), int'(rv)), 1);
      end

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule

// File: doc/gcd.md
GCD -- requirements
Module: gcd

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-high reset.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 resetb  input  1  asynchronous reset, active-high: asserted = 1, released = 0; the codebase port name is kept.
REQ-004 u  input  8  first unsigned operand, sampled on load.
REQ-005 v  input  8  second unsigned operand, sampled on load.
REQ-006 ld  input  1  load strobe; a one-cycle pulse starts a computation.
REQ-007 res  output  8  unsigned GCD result, registered.
REQ-008 done  output  1  one-cycle completion pulse, registered.

Function
REQ-009 The block SHALL compute GCD(u,v) with the binary (Stein) algorithm, one operation per clock.
REQ-010 FSM states SHALL be IDLE, CALC and DONE.
REQ-011 IDLE with ld=1 at a rising edge: capture a=u, b=v, k=0, go to CALC; ld=0 keeps IDLE.
REQ-012 CALC priority when a==0: res<=b<<k, go to DONE.
REQ-013 CALC priority when b==0 (a!=0): res<=a<<k, go to DONE.
REQ-014 CALC priority when a and b are both even: a>>=1, b>>=1, k+=1.
REQ-015 CALC priority when only a is even: a>>=1.
REQ-016 CALC priority when only b is even: b>>=1.
REQ-017 CALC priority when both are odd and a>=b: a<=(a-b)>>1.
REQ-018 CALC priority when both are odd and a<b: b<=(b-a)>>1.
REQ-019 DONE SHALL drive done=1 for exactly one cycle, then return to IDLE.
REQ-020 done SHALL be 0 in all other states, so every computation produces a distinct rising edge of done.
REQ-021 res SHALL update only on entry to DONE and SHALL hold its value until the next completion.
REQ-022 Zero operands: GCD(0,v)=v, GCD(u,0)=u, GCD(0,0)=0; each still produces a done pulse.
REQ-023 Internal width rules: a, b and the subtractions are 8-bit unsigned; k is 3 bits.
REQ-024 b<<k or a<<k SHALL be truncated to 8 bits; no overflow can occur because the result never exceeds max(u,v).
REQ-025 Latency from the ld edge to done high SHALL be at most 20 clock cycles for any 8-bit operands.
REQ-026 Latency SHALL be data dependent, with a minimum of 2 cycles (zero operand).
REQ-027 ld asserted while in CALC or DONE SHALL be ignored; the running computation is unaffected.
REQ-028 u and v are sampled only at the load edge; later changes SHALL have no effect on the running computation.
REQ-029 ld held high for several cycles in IDLE SHALL start only one computation, at the first edge.
REQ-030 A new computation from that continued ld assertion SHALL start only after returning to IDLE.

Reset
REQ-031 resetb=1 SHALL immediately, without waiting for a clock edge, force state=IDLE, res=0, done=0, a=0, b=0, k=0.
REQ-032 Reset asserted mid-computation SHALL abort it with no done pulse.
REQ-033 After resetb returns to 0, the first ld SHALL start a fresh computation.

Verification
REQ-034 Reset, then ld pulse with u=48, v=18 -> one done pulse within 20 cycles, res=6, res held afterwards.
REQ-035 u=0,v=5 -> res=5; u=7,v=0 -> res=7; u=0,v=0 -> res=0; each with exactly one done pulse.
REQ-036 u=128,v=96 -> res=32 (common factor path); u=255,v=255 -> res=255; u=1,v=200 -> res=1.
REQ-037 resetb=1 three cycles after loading u=200,v=150 -> done stays 0 and res=0.
REQ-038 After that reset, load u=200,v=150 -> res=50.
REQ-039 100 back-to-back random pairs (next ld after each done) -> every res matches the Euclidean remainder model.
REQ-040 For the same random run, u and v are held stable during each computation, and toggling ld during CALC changes nothing.
